// File: rtl/frame_streamer_if.sv
// Bundle of the frame_streamer signals: frame-memory write port, go/ack handshake and window stream.
// The master drives the write and handshake inputs; the slave (the streamer) drives the stream outputs.
interface frame_streamer_if #(parameter int W = 8);
  logic         we;
  logic [9:0]   waddr;
  logic [W-1:0] wdata;
  logic         go;
  logic         ack;
  logic [W-1:0] indata;
  logic [10:0]  cnt;
  logic [6:0]   x;
  logic [6:0]   y;
  logic         start;
  logic         win_done;
  logic         frame_done;
  logic         busy;

  modport master (
    output we, waddr, wdata, go, ack,
    input  indata, cnt, x, y, start, win_done, frame_done, busy
  );

  modport slave (
    input  we, waddr, wdata, go, ack,
    output indata, cnt, x, y, start, win_done, frame_done, busy
  );
endinterface

// File: rtl/frame_streamer.sv
// Streams a stored dim x dim frame once per window centre, in raster order, with a CLR cycle
// before each sweep and a HOLD until the consumer acknowledges the captured window.
module frame_streamer #(
  parameter int W   = 8,
  parameter int dim = 32
) (
  input  logic           clk,
  input  logic           rst,
  frame_streamer_if.slave bus
);

  localparam int          N     = dim * dim;
  localparam int          AW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [10:0] NL    = 11'(N);
  localparam logic [10:0] CLAST = 11'(N + 1);
  localparam logic [6:0]  XYMAX = 7'(dim - 1);

  typedef enum logic [2:0] {IDLE, CLR, SWEEP, HOLD, DONE} state_t;

  state_t       state;
  logic [W-1:0] mem [N];
  logic [W-1:0] indata_r;
  logic [10:0]  cnt_r;
  logic [10:0]  cnt_nxt;
  logic [6:0]   x_r;
  logic [6:0]   y_r;
  logic         start_r;
  logic         win_done_r;
  logic         frame_done_r;
  logic         busy_r;

  assign cnt_nxt = cnt_r + 11'd1;

  // Frame memory is written only while idle; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.we && ({1'b0, bus.waddr} < NL))
      mem[bus.waddr[AW-1:0]] <= bus.wdata;
  end

  // indata is read with the next cnt value so both registers present the same pixel together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      indata_r     <= '0;
      cnt_r        <= '0;
      x_r          <= '0;
      y_r          <= '0;
      start_r      <= 1'b0;
      win_done_r   <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start_r      <= 1'b0;
          cnt_r        <= '0;
          indata_r     <= '0;
          win_done_r   <= 1'b0;
          frame_done_r <= 1'b0;
          if (bus.go) begin
            state  <= CLR;
            x_r    <= '0;
            y_r    <= '0;
            busy_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        CLR: begin
          state    <= SWEEP;
          start_r  <= 1'b1;
          cnt_r    <= '0;
          indata_r <= '0;
        end
        SWEEP: begin
          if (cnt_r == CLAST) begin
            state      <= HOLD;
            win_done_r <= 1'b1;
            indata_r   <= '0;
          end else begin
            cnt_r <= cnt_nxt;
            if (cnt_nxt <= NL)
              indata_r <= mem[cnt_r[AW-1:0]];
            else
              indata_r <= '0;
          end
        end
        HOLD: begin
          if (bus.ack) begin
            win_done_r <= 1'b0;
            start_r    <= 1'b0;
            cnt_r      <= '0;
            indata_r   <= '0;
            if (x_r == XYMAX && y_r == XYMAX) begin
              state        <= DONE;
              frame_done_r <= 1'b1;
            end else begin
              state <= CLR;
              if (x_r == XYMAX) begin
                x_r <= '0;
                y_r <= y_r + 7'd1;
              end else begin
                x_r <= x_r + 7'd1;
              end
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          frame_done_r <= 1'b0;
          busy_r       <= 1'b0;
          start_r      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.indata     = indata_r;
  assign bus.cnt        = cnt_r;
  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.start      = start_r;
  assign bus.win_done   = win_done_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer at dim=4: frame load, sweeps, hold/ack, ignored writes and go,
// mid-frame reset abort and re-streaming of the stored frame.
module tb_frame_streamer;

  localparam int W   = 8;
  localparam int DIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   errors = 0;

  frame_streamer_if #(.W(W)) bus ();

  frame_streamer #(.W(W), .dim(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [9:0] waddr, input logic [W-1:0] wdata,
                               input logic go, input logic ack);
    bus.we    = we;
    bus.waddr = waddr;
    bus.wdata = wdata;
    bus.go    = go;
    bus.ack   = ack;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cnt"},        32'(bus.cnt), 0);
    checkOutput({tag, " x"},          32'(bus.x), 0);
    checkOutput({tag, " y"},          32'(bus.y), 0);
    checkOutput({tag, " start"},      32'(bus.start), 0);
    checkOutput({tag, " win_done"},   32'(bus.win_done), 0);
    checkOutput({tag, " frame_done"}, 32'(bus.frame_done), 0);
    checkOutput({tag, " busy"},       32'(bus.busy), 0);
    checkOutput({tag, " indata"},     32'(bus.indata), 0);
  endtask

  // Entered in the CLR cycle of a window; returns in the CLR/DONE cycle after the ack.
  task automatic sweepWindow(input int ex, input int ey, input int holdCycles,
                             input bit inject, input int abortAt, output bit aborted);
    int expPix;
    aborted = 1'b0;
    checkOutput("clr start", 32'(bus.start), 0);
    checkOutput("clr cnt",   32'(bus.cnt), 0);
    checkOutput("clr x",     32'(bus.x), 32'(ex));
    checkOutput("clr y",     32'(bus.y), 32'(ey));
    checkOutput("clr busy",  32'(bus.busy), 1);
    tick();
    for (int c = 0; c <= DIM*DIM + 1; c++) begin
      expPix = (c == 0 || c == DIM*DIM + 1) ? 0 : c + 15;
      checkOutput("sweep cnt",    32'(bus.cnt), 32'(c));
      checkOutput("sweep indata", 32'(bus.indata), 32'(expPix));
      checkOutput("sweep start",  32'(bus.start), 1);
      if (c == abortAt) begin
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        aborted = 1'b1;
        return;
      end
      if (inject && c == 5)
        applyStimulus(1'b1, 10'd5, 8'hEE, 1'b1, 1'b0);
      else
        applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("hold win_done", 32'(bus.win_done), 1);
    checkOutput("hold cnt",      32'(bus.cnt), 32'(DIM*DIM + 1));
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      checkOutput("hold stable win_done",   32'(bus.win_done), 1);
      checkOutput("hold stable start",      32'(bus.start), 1);
      checkOutput("hold stable cnt",        32'(bus.cnt), 32'(DIM*DIM + 1));
      checkOutput("hold stable indata",     32'(bus.indata), 0);
      checkOutput("hold stable frame_done", 32'(bus.frame_done), 0);
    end
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("post ack win_done", 32'(bus.win_done), 0);
  endtask

  task automatic runFrame(input int abortWin, output bit aborted);
    aborted = 1'b0;
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
    for (int w = 0; w < DIM*DIM; w++) begin
      sweepWindow(w % DIM, w / DIM, 0, 1'b0, (w == abortWin) ? 7 : -1, aborted);
      if (aborted) return;
      if (w != DIM*DIM - 1)
        checkOutput("no early frame_done", 32'(bus.frame_done), 0);
    end
    checkOutput("frame_done pulse", 32'(bus.frame_done), 1);
    checkOutput("done start",       32'(bus.start), 0);
    checkOutput("done busy",        32'(bus.busy), 1);
    tick();
    checkOutput("frame_done cleared", 32'(bus.frame_done), 0);
    checkOutput("busy fallen",        32'(bus.busy), 0);
  endtask

  initial begin
    bit ab;
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
    #12;
    checkAllZero("reset");
    rst = 1'b1;
    tick();
    checkAllZero("idle");

    for (int k = 0; k < DIM*DIM; k++) begin
      applyStimulus(1'b1, 10'(k), 8'(k + 16), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 10'd20, 8'hAA, 1'b0, 1'b0);
    tick();
    checkOutput("idle while writing", 32'(bus.busy), 0);

    // First frame: long hold on window 0, plus write and go injected mid-sweep.
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
    sweepWindow(0, 0, 10, 1'b1, -1, ab);
    for (int w = 1; w < DIM*DIM; w++) begin
      sweepWindow(w % DIM, w / DIM, (w == 1) ? 2 : 0, 1'b0, -1, ab);
    end
    checkOutput("frame_done pulse", 32'(bus.frame_done), 1);
    checkOutput("done busy",        32'(bus.busy), 1);
    tick();
    checkOutput("frame_done cleared", 32'(bus.frame_done), 0);
    checkOutput("busy fallen",        32'(bus.busy), 0);

    // Second frame aborted by reset in window (1,1) at cnt=7.
    runFrame(5, ab);
    checkOutput("abort taken", 32'(ab), 1);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checkAllZero("after abort");
    tick();
    checkOutput("no frame_done after abort", 32'(bus.frame_done), 0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0);

    // Third frame streams the persisted memory untouched.
    runFrame(-1, ab);
    checkOutput("no abort", 32'(ab), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter W, default 8, pixel width in bits.
REQ-002 Parameter dim, default 32, frame edge length in pixels (N = dim*dim pixels).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 we  input  1  frame-memory write strobe, honoured only in IDLE.
REQ-006 waddr  input  10  frame-memory write address, raster order y*dim+x.
REQ-007 wdata  input  W  frame-memory write data.
REQ-008 go  input  1  start streaming the stored frame, sampled only in IDLE.
REQ-009 ack  input  1  consumer has taken the current window, sampled only in HOLD.
REQ-010 indata  output  W  streamed pixel, registered.
REQ-011 cnt  output  11  stream index, 1-based pixel position y*dim+x+1, registered.
REQ-012 x, y  output  7 each  current window centre column/row, registered.
REQ-013 start  output  1  window-capture enable for the consumer; low clears its window registers.
REQ-014 win_done  output  1  high while a complete sweep is held for the consumer.
REQ-015 frame_done  output  1  one-cycle pulse after the last window is acknowledged.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Internal frame memory SHALL hold N words of W bits; write when we=1 in IDLE, mem[waddr]<=wdata; writes in other states and waddr>=N SHALL be ignored.
REQ-018 States SHALL be IDLE, CLR, SWEEP, HOLD, DONE.
REQ-019 IDLE: start=0, cnt=0, indata=0; go=1 -> CLR with x=0, y=0; simultaneous we and go SHALL perform the write and take go.
REQ-020 CLR: exactly one cycle, start=0, cnt=0 -> SWEEP.
REQ-021 SWEEP: start=1; cnt SHALL advance by 1 per cycle from 0 to N+1 inclusive, no gaps.
REQ-022 In SWEEP, indata SHALL equal mem[cnt-1] in the same cycle cnt is presented for 1<=cnt<=N, and 0 for cnt=0 and cnt=N+1.
REQ-023 The cycle after cnt=N+1 -> HOLD; SWEEP length SHALL be N+2 cycles.
REQ-024 HOLD: start=1, win_done=1, cnt held at N+1, indata=0; remain until ack=1.
REQ-025 ack in HOLD, window not last: x<=x+1; if x=dim-1 then x<=0, y<=y+1; -> CLR.
REQ-026 ack in HOLD at x=dim-1, y=dim-1 -> DONE; DONE lasts one cycle with frame_done=1, start=0 -> IDLE.
REQ-027 ack outside HOLD and go outside IDLE SHALL be ignored.
REQ-028 Window order SHALL be raster, dim*dim windows per frame, each preceded by a CLR cycle.
REQ-029 Frame memory contents SHALL persist across frames; a second go re-streams the same frame without rewrite.
REQ-030 cnt, x, y SHALL never exceed N+1, dim-1, dim-1 respectively.

Reset
REQ-031 rst=0 at any time SHALL force IDLE immediately: start=0, win_done=0, frame_done=0, busy=0, cnt=0, x=0, y=0, indata=0.
REQ-032 Reset SHALL NOT be required to clear frame memory; contents after reset are undefined until rewritten.
REQ-033 Reset mid-SWEEP or mid-HOLD SHALL abort the frame with no frame_done pulse.

Verification
REQ-034 dim=4, write mem[k]=k+16 for k=0..15, go -> CLR 1 cycle, then cnt 0..17 with indata 0,16,17..31,0, then win_done=1.
REQ-035 Hold ack low 10 cycles in HOLD -> win_done, start, cnt=17 stable; ack pulse -> x=1,y=0, start=0 for one cycle, new sweep.
REQ-036 Ack every window at dim=4 -> 16 sweeps, x,y follow (0,0)..(3,3) raster, frame_done single pulse, busy falls next cycle.
REQ-037 we=1 with waddr=5 during SWEEP -> mem[5] unchanged on next frame; go during SWEEP -> no restart.
REQ-038 rst low during sweep at cnt=7 -> all outputs zero asynchronously, IDLE, no frame_done; subsequent go streams normally.
